// File: rtl/gpu_clut_load_sequencer_pkg.sv
// gpu_clut_load_sequencer_pkg: shared state, packet-count and tag types for the CLUT load sequencer
package gpu_clut_load_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} clut_seq_state_t;
  localparam logic [3:0] CLUT_PKT_4BPP = 4'd0;
  localparam logic [3:0] CLUT_PKT_8BPP = 4'd15;
  typedef struct packed {
    logic        valid;
    logic [14:0] adr;
    logic        is8;
  } clut_tag_t;
endpackage

// File: rtl/gpu_clut_load_sequencer_if.sv
// gpu_clut_load_sequencer_if: request, VRAM read and CLUT write signals of the CLUT load sequencer
// master = sequencer side; slave = decoder/arbiter/CLUT RAM side.
interface gpu_clut_load_sequencer_if;
  logic        i_start;
  logic [14:0] i_clutAdr;
  logic        i_is8BPP;
  logic        i_invalidate;
  logic        o_memReq;
  logic [14:0] o_memAdr;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [31:0] i_memData;
  logic        o_clutWrite;
  logic [6:0]  o_clutWrAdr;
  logic [31:0] o_clutWrData;
  logic        o_busy;
  logic        o_done;
  logic        o_hit;
  modport master (
    input  i_start, i_clutAdr, i_is8BPP, i_invalidate, i_memAck, i_memDataValid, i_memData,
    output o_memReq, o_memAdr, o_clutWrite, o_clutWrAdr, o_clutWrData, o_busy, o_done, o_hit
  );
  modport slave (
    output i_start, i_clutAdr, i_is8BPP, i_invalidate, i_memAck, i_memDataValid, i_memData,
    input  o_memReq, o_memAdr, o_clutWrite, o_clutWrAdr, o_clutWrData, o_busy, o_done, o_hit
  );
endinterface

// File: rtl/gpu_clut_load_sequencer.sv
// gpu_clut_load_sequencer: fills the CLUT cache from VRAM in 32-byte bursts on a tag miss
// Ports: i_clk, i_rstGPU (async, active high), bus (master modport: start/tag request,
// VRAM burst request and read beats, CLUT write port, busy/done/hit status).
module gpu_clut_load_sequencer
  import gpu_clut_load_sequencer_pkg::*;
#(
  parameter int BEATS_PER_PACKET = 8,
  parameter bit TAG_CHECK        = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rstGPU,
  gpu_clut_load_sequencer_if.master   bus
);
  clut_seq_state_t state, nextState;
  clut_tag_t       tag;
  logic [14:0]     curAdr;
  logic            cur8;
  logic [3:0]      packet;
  logic [2:0]      beat;
  logic            doneR, hitR;
  logic            startOk, hit, lastBeat, lastPacket, finish;
  assign startOk    = state == IDLE && bus.i_start;
  // A same-cycle invalidate wins over the tag, forcing the request to miss.
  assign hit        = TAG_CHECK && tag.valid && !bus.i_invalidate && tag.adr == bus.i_clutAdr
                      && (tag.is8 || !bus.i_is8BPP);
  assign lastBeat   = bus.i_memDataValid && beat == 3'(BEATS_PER_PACKET - 1);
  assign lastPacket = packet == (cur8 ? CLUT_PKT_8BPP : CLUT_PKT_4BPP);
  assign finish     = state == DATA && lastBeat && lastPacket && !bus.i_invalidate;
  always_ff @(posedge i_clk or posedge i_rstGPU)
    if (i_rstGPU) state <= IDLE;
    else          state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = startOk && !hit ? REQ : IDLE;
      REQ:     nextState = bus.i_invalidate ? (bus.i_memAck ? DRAIN : IDLE) : (bus.i_memAck ? DATA : REQ);
      DATA:    nextState = !lastBeat ? (bus.i_invalidate ? DRAIN : DATA)
                                     : (bus.i_invalidate || lastPacket ? IDLE : REQ);
      DRAIN:   nextState = lastBeat ? IDLE : DRAIN;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rstGPU)
    if (i_rstGPU) begin
      tag    <= '0;
      curAdr <= '0;
      cur8   <= 1'b0;
      packet <= '0;
      beat   <= '0;
      doneR  <= 1'b0;
      hitR   <= 1'b0;
    end else begin
      doneR <= (startOk && hit) || finish;
      hitR  <= startOk && hit;
      if (startOk && !hit) begin
        curAdr <= bus.i_clutAdr;
        cur8   <= bus.i_is8BPP;
        packet <= '0;
      end
      if (state == REQ && bus.i_memAck) beat <= '0;
      if ((state == DATA || state == DRAIN) && bus.i_memDataValid) beat <= beat + 3'd1;
      if (state == DATA && lastBeat && !lastPacket) packet <= packet + 4'd1;
      if (bus.i_invalidate || (startOk && !hit)) tag.valid <= 1'b0;
      else if (finish) tag <= '{valid: 1'b1, adr: curAdr, is8: cur8};
    end
  always_comb begin
    bus.o_memReq     = state == REQ;
    // X16 wraps inside its 6-bit field so a palette never spills into the next row.
    bus.o_memAdr     = {curAdr[14:6], curAdr[5:0] + {2'b00, packet}};
    bus.o_clutWrite  = state == DATA && bus.i_memDataValid;
    bus.o_clutWrAdr  = {packet, beat};
    bus.o_clutWrData = bus.i_memData;
    bus.o_busy       = state != IDLE;
    bus.o_done       = doneR;
    bus.o_hit        = hitR;
  end
endmodule

// File: tb/tb_gpu_clut_load_sequencer.sv
// tb_gpu_clut_load_sequencer: directed scoreboard bench for the CLUT load sequencer
module tb_gpu_clut_load_sequencer;
  typedef struct packed {
    logic [6:0]  idx;
    logic [31:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nAsserts = 0;
  int   nFail = 0;
  wr_t  expWr[$];
  wr_t  e;
  logic [14:0] a8 = {9'd100, 6'd60};
  always #5 clk = ~clk;
  gpu_clut_load_sequencer_if bus();
  gpu_clut_load_sequencer #(.BEATS_PER_PACKET(8), .TAG_CHECK(1)) dut (
    .i_clk(clk),
    .i_rstGPU(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.o_clutWrite) begin
      if (expWr.size() == 0) chk("unexpectedWrite", 32'(1), 32'(0));
      else begin
        e = expWr.pop_front();
        chk("wrAdr", 32'(bus.o_clutWrAdr), 32'(e.idx));
        chk("wrData", bus.o_clutWrData, e.data);
      end
    end
    if (bus.i_start) chk("startWhileBusy", 32'(bus.o_busy), 32'(0));
    if (bus.i_memDataValid) chk("validOutsideData", 32'(bus.o_busy && !bus.o_memReq), 32'(1));
    chk("hitWithoutDone", 32'(bus.o_hit && !bus.o_done), 32'(0));
  end
  task automatic checkZero(input string tag);
    chk({tag, ".memReq"}, 32'(bus.o_memReq), 32'(0));
    chk({tag, ".memAdr"}, 32'(bus.o_memAdr), 32'(0));
    chk({tag, ".clutWrite"}, 32'(bus.o_clutWrite), 32'(0));
    chk({tag, ".clutWrAdr"}, 32'(bus.o_clutWrAdr), 32'(0));
    chk({tag, ".clutWrData"}, bus.o_clutWrData, 32'(0));
    chk({tag, ".busy"}, 32'(bus.o_busy), 32'(0));
    chk({tag, ".done"}, 32'(bus.o_done), 32'(0));
    chk({tag, ".hit"}, 32'(bus.o_hit), 32'(0));
  endtask
  task automatic burst(input logic [14:0] adr, input int p, input int invBeat, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!bus.o_memReq && n < 50) begin
      step();
      n++;
    end
    chk("reqTimeout", 32'(bus.o_memReq), 32'(1));
    if (!bus.o_memReq) begin
      ok = 1'b0;
      return;
    end
    chk("memAdr", 32'(bus.o_memAdr), 32'({adr[14:6], 6'(adr[5:0] + 6'(p))}));
    bus.i_memAck = 1'b1;
    step();
    bus.i_memAck = 1'b0;
    chk("reqDrop", 32'(bus.o_memReq), 32'(0));
    for (int b = 0; b < 8; b++) begin
      bus.i_memDataValid = 1'b1;
      bus.i_memData = $urandom;
      if (invBeat < 0 || b <= invBeat) expWr.push_back('{idx: {4'(p), 3'(b)}, data: bus.i_memData});
      bus.i_invalidate = (b == invBeat);
      step();
      bus.i_invalidate = 1'b0;
      if (b < 7) chk("busyInBurst", 32'(bus.o_busy), 32'(1));
    end
    bus.i_memDataValid = 1'b0;
    bus.i_memData = '0;
  endtask
  task automatic load(input logic [14:0] adr, input bit is8, input int invPkt, input int invBeat,
                      input bit withInv);
    bit ok;
    int np = is8 ? 16 : 1;
    bus.i_start = 1'b1;
    bus.i_clutAdr = adr;
    bus.i_is8BPP = is8;
    bus.i_invalidate = withInv;
    step();
    bus.i_start = 1'b0;
    bus.i_invalidate = 1'b0;
    chk("missNoDone", 32'(bus.o_done), 32'(0));
    for (int p = 0; p < np; p++) begin
      burst(adr, p, p == invPkt ? invBeat : -1, ok);
      if (!ok || p == invPkt) break;
    end
    chk("endBusy", 32'(bus.o_busy), 32'(0));
    chk("endDone", 32'(bus.o_done), 32'(invPkt < 0));
    chk("endHit", 32'(bus.o_hit), 32'(0));
    step();
    chk("donePulse", 32'(bus.o_done), 32'(0));
    chk("sbEmpty", 32'(expWr.size()), 32'(0));
  endtask
  task automatic hitCheck(input logic [14:0] adr, input bit is8);
    bus.i_start = 1'b1;
    bus.i_clutAdr = adr;
    bus.i_is8BPP = is8;
    step();
    bus.i_start = 1'b0;
    chk("hitDone", 32'(bus.o_done), 32'(1));
    chk("hitHit", 32'(bus.o_hit), 32'(1));
    chk("hitNoReq", 32'(bus.o_memReq), 32'(0));
    chk("hitBusy", 32'(bus.o_busy), 32'(0));
    step();
    chk("hitPulse", 32'(bus.o_done), 32'(0));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_clutAdr = '0;
    bus.i_is8BPP = 1'b0;
    bus.i_invalidate = 1'b0;
    bus.i_memAck = 1'b0;
    bus.i_memDataValid = 1'b0;
    bus.i_memData = '0;
    #12;
    checkZero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    load(15'h1234, 1'b0, -1, 0, 1'b0);
    hitCheck(15'h1234, 1'b0);
    load(a8, 1'b1, -1, 0, 1'b0);
    hitCheck(a8, 1'b0);
    load(a8, 1'b0, -1, 0, 1'b1);
    load(15'h2222, 1'b0, -1, 0, 1'b0);
    load(15'h2222, 1'b1, -1, 0, 1'b0);
    load(15'h0500, 1'b0, -1, 0, 1'b0);
    load(15'h0500, 1'b1, 3, 4, 1'b0);
    load(15'h0500, 1'b0, -1, 0, 1'b0);
    load(15'h0600, 1'b1, -1, 0, 1'b0);
    hitCheck(15'h0600, 1'b0);
    bus.i_invalidate = 1'b1;
    step();
    bus.i_invalidate = 1'b0;
    load(15'h0600, 1'b0, -1, 0, 1'b0);
    bus.i_start = 1'b1;
    bus.i_clutAdr = 15'h0ABC;
    bus.i_is8BPP = 1'b0;
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bpReq", 32'(bus.o_memReq), 32'(1));
      chk("bpAdr", 32'(bus.o_memAdr), 32'(15'h0ABC));
      step();
    end
    bus.i_invalidate = 1'b1;
    chk("bpReqInv", 32'(bus.o_memReq), 32'(1));
    step();
    bus.i_invalidate = 1'b0;
    chk("bpAbortReq", 32'(bus.o_memReq), 32'(0));
    chk("bpAbortBusy", 32'(bus.o_busy), 32'(0));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bpIdleReq", 32'(bus.o_memReq), 32'(0));
      chk("bpNoDone", 32'(bus.o_done), 32'(0));
    end
    load(15'h3333, 1'b0, -1, 0, 1'b0);
    bus.i_start = 1'b1;
    bus.i_clutAdr = 15'h4444;
    bus.i_is8BPP = 1'b0;
    step();
    bus.i_start = 1'b0;
    chk("rstReq", 32'(bus.o_memReq), 32'(1));
    bus.i_memAck = 1'b1;
    step();
    bus.i_memAck = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.i_memDataValid = 1'b1;
      bus.i_memData = $urandom;
      expWr.push_back('{idx: {4'd0, 3'(b)}, data: bus.i_memData});
      step();
    end
    bus.i_memDataValid = 1'b0;
    bus.i_memData = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkZero("asyncRst");
    chk("rstSbEmpty", 32'(expWr.size()), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    step();
    load(15'h3333, 1'b0, -1, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule

// File: doc/gpu_clut_load_sequencer.md
Name: gpu_clut_load_sequencer

Overview:
- Sequences palette (CLUT) fills from VRAM into the CLUT cache RAM on behalf of the primitive setup stage.
- On a start request it checks the CLUT tag and, on a miss, issues 1 (4bpp) or 16 (8bpp) 32-byte burst reads to the memory arbiter. It writes returned beats into the CLUT cache and reports completion.
- It sits between the command/primitive decoder, the VRAM memory arbiter and the CLUT cache RAM.

Parameters:
- BEATS_PER_PACKET, 8, 32-bit beats per 16-entry CLUT packet. Fixed; only 8 is supported.
- TAG_CHECK, 1, 1 = skip loads that hit the tag; 0 = always load (debug).

Ports:
- i_clk  in  1  clock
- i_rstGPU  in  1  asynchronous active-high reset
- i_start  in  1  load request pulse; honoured only when o_busy=0
- i_clutAdr  in  15  CLUT location {Y[8:0], X16[5:0]}; X16 is in 16-pixel units
- i_is8BPP  in  1  1 = 256-entry palette (16 packets); 0 = 16-entry palette (1 packet)
- i_invalidate  in  1  texture/CLUT cache flush pulse
- o_memReq  out  1  burst read request, held until acknowledged
- o_memAdr  out  15  32-byte block address {Y, X16}
- i_memAck  in  1  arbiter accepted the request
- i_memDataValid  in  1  read beat valid
- i_memData  in  32  read beat; two 15-bit+mask CLUT entries, low halfword first
- o_clutWrite  out  1  CLUT cache write strobe
- o_clutWrAdr  out  7  entry-pair index {packet[3:0], beat[2:0]}
- o_clutWrData  out  32  pass-through of i_memData
- o_busy  out  1  load in progress (includes drain)
- o_done  out  1  one-cycle pulse: palette usable
- o_hit  out  1  valid together with o_done; 1 = no load was performed

Behaviour:
- Reset (async): state=IDLE, tag invalid (tagValid=0, tagAdr=0, tag8=0). All outputs 0.
- Registers: tagValid, tagAdr[14:0], tag8, curAdr, cur8, packet[3:0], beat[2:0], state.
- Hit condition: TAG_CHECK && tagValid && tagAdr==i_clutAdr && (tag8 || !i_is8BPP). A loaded 8bpp palette covers a 4bpp request at the same address; the reverse does not.
- IDLE + i_start + hit: next cycle o_done=1, o_hit=1; stay IDLE. Latency 1.
- IDLE + i_start + miss: latch curAdr and cur8, packet=0, tagValid<=0. Next state REQ.
- REQ: o_memReq=1, o_memAdr={curAdr[14:6], curAdr[5:0]+packet} with 6-bit wrap (X stays in its row, no carry into Y).
  - On i_memAck, go to DATA with beat=0; the request drops the cycle after the ack.
- DATA: each i_memDataValid gives o_clutWrite=1 combinationally in that cycle, o_clutWrAdr={packet,beat}, and beat++.
  - On beat==7 with packet!=last (last=15 if cur8, else 0): packet++, return to REQ. Minimum 1 idle cycle between bursts.
  - On beat==7 with packet==last: tagValid<=1, tagAdr<=curAdr, tag8<=cur8; o_done=1, o_hit=0 the next cycle; go to IDLE.
  - Best case 4bpp load: 1 REQ cycle + ack + 8 beats + 1 cycle to o_done.
- i_invalidate:
  - In IDLE, or in any state: clears tagValid in the same edge.
  - In REQ before the ack (including the same cycle as the ack is absent): go to IDLE, no o_done.
  - In REQ on the same cycle as i_memAck, or in DATA: go to DRAIN.
- DRAIN: consume the remaining beats of the outstanding burst with no o_clutWrite. After the 8th beat, go to IDLE with no o_done and the tag left invalid. o_busy=1 throughout.
- i_start with o_busy=1: ignored. This is a protocol violation and the bench asserts on it.
- i_start and i_invalidate in the same cycle in IDLE: invalidate first, so the request is a forced miss and a load starts.
- i_memDataValid outside DATA/DRAIN: ignored; the bench asserts on it.
- o_busy = (state != IDLE).
- o_hit is 0 whenever o_done is 0.

Decomposition:
- gpu_pkg additions:
  - typedef enum clut_seq_state_t {IDLE, REQ, DATA, DRAIN}
  - localparam CLUT_PKT_4BPP=0, CLUT_PKT_8BPP=15
  - typedef struct clut_tag_t {valid, adr[14:0], is8}
- No sub-module. The tag compare stays inline; a separate gpu_clut_tag module is not justified at this size.

Test Plan:
- 4bpp miss: after reset, start adr=15'h1234, is8=0 -> one request, o_memAdr=15'h1234; 8 writes at pair idx 0..7; o_done=1, o_hit=0. Repeat start -> o_done/o_hit=1 one cycle later with no o_memReq.
- 8bpp wrap: start adr={9'd100, 6'd60}, is8=1 -> 16 requests with X16 = 60,61,62,63,0,1,…,11 and Y fixed at 100; 128 writes, idx 0..127. Then a 4bpp start at the same adr -> hit.
- 4bpp then 8bpp at the same adr: second start misses and performs 16 bursts; o_hit=0.
- Invalidate mid-burst: 8bpp load, pulse i_invalidate at packet 3 beat 4 -> no writes for beats 5..7, o_busy drops after the 8th beat, no o_done. Next start at the same adr misses.
- Arbiter backpressure: hold i_memAck low for 20 cycles -> o_memReq and o_memAdr stable throughout; invalidate pulsed at cycle 10 -> IDLE next cycle, o_memReq=0.
- Async reset asserted mid-DATA, between clock edges -> all outputs 0 immediately; the following start at the previously loaded adr misses.
